// File: rtl/fetch_pkg.sv
// Shared definitions for the IRAM fetch sequencer: FSM states, the default PC width,
// and the sizing of the IRAM latency counter.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    VALID = 3'd4
  } fetch_state_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_IRAM_LAT = 1;
  localparam int LAT_CNT_W    = $clog2(DEF_IRAM_LAT + 1);

  // Width of a counter that can hold the IRAM latency value itself.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch sequencer: jump load, increment, and the
// top-of-space behaviour. With PC_HALT_ON_WRAP_EN defined, incrementing from the
// last address holds pc and sets a sticky halted flag; otherwise pc wraps to 0.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              halt_hit
);

`ifdef PC_HALT_ON_WRAP_EN
  // An increment at the last address is the only event that halts; a jump there is taken.
  always_comb begin
    halt_hit = adv && !jump_en && (&pc);
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        halted <= 1'b0;
    else if (halt_hit) halted <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // PC update on an acknowledged instruction: jump, else increment unless halting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (adv) begin
      if (jump_en)        pc <= jump_addr;
      else if (!halt_hit) pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/iram_fetch_ctrl.sv
// Fetch sequencer upstream of the MBRU. Addresses the IRAM from pc, waits out the
// IRAM read latency, pulses fetch for one cycle so the MBRU captures the data, then
// holds ins_valid until the decoder acknowledges. Build option: PC_HALT_ON_WRAP_EN.
//
//  state | meaning
//  IDLE  | not fetching; waits for run (ignored once halted)
//  REQ   | address presented, IRAM read enabled
//  WAIT  | remaining IRAM latency, IRAM_LAT-1 cycles
//  LOAD  | IRAM data valid; fetch strobe to MBRU
//  VALID | instruction held for the decoder until ins_ready
module iram_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                IRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              ins_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              iram_en,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              fetch,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int CNT_W     = lat_cnt_w(IRAM_LAT);
  localparam int WAIT_INIT = (IRAM_LAT >= 2) ? IRAM_LAT - 2 : 0;

  fetch_state_t     state, state_nxt;
  logic [CNT_W-1:0] lat_cnt;
  logic             adv;
  logic             halt_hit;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc),
    .halted    (halted),
    .halt_hit  (halt_hit)
  );

  assign iram_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latency down-counter: loaded in REQ, WAIT ends when it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                lat_cnt <= '0;
    else if (state == REQ)                     lat_cnt <= CNT_W'(WAIT_INIT);
    else if (state == WAIT && lat_cnt != '0)   lat_cnt <= lat_cnt - 1'b1;
  end

  // Next state and strobes; outputs depend on state only so reset clears them at once.
  always_comb begin
    state_nxt = state;
    iram_en   = 1'b0;
    fetch     = 1'b0;
    ins_valid = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (run && !halted) state_nxt = REQ;
      end
      REQ: begin
        iram_en   = 1'b1;
        state_nxt = (IRAM_LAT == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        iram_en = 1'b1;
        if (lat_cnt == '0) state_nxt = LOAD;
      end
      LOAD: begin
        iram_en   = 1'b1;
        fetch     = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        ins_valid = 1'b1;
        if (ins_ready) begin
          adv       = 1'b1;
          state_nxt = (run && !halt_hit) ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iram_fetch_ctrl.sv
// Directed bench for iram_fetch_ctrl. Two instances: IRAM_LAT=1 (dut_a) and
// IRAM_LAT=3 (dut_b). Stimulus pushes the address each fetch pulse must present;
// per-instance monitors pop and compare on every fetch strobe.
module tb_iram_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       rst_n_a, run_a, rdy_a, jen_a;
  logic [7:0] jaddr_a;
  logic       iram_en_a, fetch_a, ins_valid_a, halted_a;
  logic [7:0] iram_addr_a, pc_a;

  logic       rst_n_b, run_b, rdy_b, jen_b;
  logic [7:0] jaddr_b;
  logic       iram_en_b, fetch_b, ins_valid_b, halted_b;
  logic [7:0] iram_addr_b, pc_b;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ea, eb;

  iram_fetch_ctrl #(.ADDR_W(8), .IRAM_LAT(1), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .run(run_a), .ins_ready(rdy_a),
    .jump_en(jen_a), .jump_addr(jaddr_a), .iram_en(iram_en_a),
    .iram_addr(iram_addr_a), .fetch(fetch_a), .ins_valid(ins_valid_a),
    .pc(pc_a), .halted(halted_a)
  );

  iram_fetch_ctrl #(.ADDR_W(8), .IRAM_LAT(3), .RESET_PC(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .run(run_b), .ins_ready(rdy_b),
    .jump_en(jen_b), .jump_addr(jaddr_b), .iram_en(iram_en_b),
    .iram_addr(iram_addr_b), .fetch(fetch_b), .ins_valid(ins_valid_b),
    .pc(pc_b), .halted(halted_b)
  );

  // Scoreboard monitor for dut_a: each fetch pulse must match the next expected address.
  always @(negedge clk) begin
    if (rst_n_a && fetch_a) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL a_fetch_unexpected: got fetch at addr %0h, none expected", iram_addr_a);
      end else begin
        ea = qa.pop_front();
        if (iram_addr_a !== ea) begin
          n_err++;
          $display("FAIL a_fetch_addr: got %0h expected %0h", iram_addr_a, ea);
        end
      end
    end
  end

  // Scoreboard monitor for dut_b.
  always @(negedge clk) begin
    if (rst_n_b && fetch_b) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL b_fetch_unexpected: got fetch at addr %0h, none expected", iram_addr_b);
      end else begin
        eb = qb.pop_front();
        if (iram_addr_b !== eb) begin
          n_err++;
          $display("FAIL b_fetch_addr: got %0h expected %0h", iram_addr_b, eb);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0; run_a = 1'b0; rdy_a = 1'b0; jen_a = 1'b0; jaddr_a = 8'h00;
    rst_n_b = 1'b0; run_b = 1'b0; rdy_b = 1'b0; jen_b = 1'b0; jaddr_b = 8'h00;
    #12;
    chk("rst_pc",        pc_a,        8'h00);
    chk("rst_iram_en",   iram_en_a,   1'b0);
    chk("rst_fetch",     fetch_a,     1'b0);
    chk("rst_ins_valid", ins_valid_a, 1'b0);
    chk("rst_halted",    halted_a,    1'b0);

    // Test 1: IRAM_LAT=1 streaming, one instruction per 3 cycles.
    @(negedge clk);
    rst_n_a = 1'b1; run_a = 1'b1; rdy_a = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      qa.push_back(8'(k));
      chk("t1_req_en",    iram_en_a,   1'b1);
      chk("t1_req_fetch", fetch_a,     1'b0);
      chk("t1_req_addr",  iram_addr_a, 32'(k));
      tick();
      chk("t1_load_fetch", fetch_a,     1'b1);
      chk("t1_load_valid", ins_valid_a, 1'b0);
      tick();
      chk("t1_valid",      ins_valid_a, 1'b1);
      chk("t1_valid_fetch", fetch_a,    1'b0);
      chk("t1_valid_pc",   pc_a,        32'(k));
      if (k == 2) run_a = 1'b0;
      tick();
    end
    chk("t1_idle_en", iram_en_a, 1'b0);
    chk("t1_idle_pc", pc_a,      8'h03);
    tick();
    chk("t1_idle_hold", iram_en_a, 1'b0);

    // Test 3: jumps, and jump_en without ins_ready is ignored.
    run_a = 1'b1; rdy_a = 1'b0;
    tick();
    qa.push_back(8'h03);
    tick(); tick();
    chk("t3_valid", ins_valid_a, 1'b1);
    jen_a = 1'b1; jaddr_a = 8'h10;
    tick();
    chk("t3_nojump_valid", ins_valid_a, 1'b1);
    chk("t3_nojump_pc",    pc_a,        8'h03);
    rdy_a = 1'b1;
    tick();
    qa.push_back(8'h10);
    chk("t3_jump10_addr", iram_addr_a, 8'h10);
    jen_a = 1'b0; rdy_a = 1'b0;
    tick(); tick();
    jen_a = 1'b1; jaddr_a = 8'h80; rdy_a = 1'b1;
    tick();
    qa.push_back(8'h80);
    chk("t3_jump80_addr", iram_addr_a, 8'h80);
    chk("t3_jump80_en",   iram_en_a,   1'b1);

    // Test 5: increment from 0xFF.
    rdy_a = 1'b0; jen_a = 1'b0;
    tick(); tick();
    jen_a = 1'b1; jaddr_a = 8'hFF; rdy_a = 1'b1;
    tick();
    qa.push_back(8'hFF);
    chk("t5_at_ff", iram_addr_a, 8'hFF);
    jen_a = 1'b0; rdy_a = 1'b0;
    tick(); tick();
    rdy_a = 1'b1;
    tick();
`ifdef PC_HALT_ON_WRAP_EN
    chk("t5_halt_pc",     pc_a,      8'hFF);
    chk("t5_halt_flag",   halted_a,  1'b1);
    chk("t5_halt_idle",   iram_en_a, 1'b0);
    tick(); tick();
    chk("t5_halt_norun",  iram_en_a, 1'b0);
    chk("t5_halt_sticky", halted_a,  1'b1);
`else
    qa.push_back(8'h00);
    chk("t5_wrap_addr", iram_addr_a, 8'h00);
    chk("t5_wrap_en",   iram_en_a,   1'b1);
    chk("t5_halted0",   halted_a,    1'b0);
    run_a = 1'b0;
    tick(); tick();
    tick();
    chk("t5_wrap_idle_pc", pc_a,      8'h01);
    chk("t5_wrap_idle_en", iram_en_a, 1'b0);
`endif

    // Test 6: reset asserted during LOAD clears strobes immediately.
    rst_n_a = 1'b0; rdy_a = 1'b0; run_a = 1'b0;
    #3;
    rst_n_a = 1'b1; run_a = 1'b1;
    tick();
    chk("t6_req_addr", iram_addr_a, 8'h00);
    tick();
    chk("t6_load_fetch", fetch_a, 1'b1);
    #2;
    rst_n_a = 1'b0;
    #1;
    chk("t6_rst_fetch",  fetch_a,     1'b0);
    chk("t6_rst_en",     iram_en_a,   1'b0);
    chk("t6_rst_valid",  ins_valid_a, 1'b0);
    chk("t6_rst_pc",     pc_a,        8'h00);
    chk("t6_rst_halted", halted_a,    1'b0);

    // Test 2: IRAM_LAT=3, decoder stalls 5 cycles in VALID.
    @(negedge clk);
    rst_n_b = 1'b1; run_b = 1'b1; rdy_b = 1'b0;
    tick();
    qb.push_back(8'h00);
    chk("t2_req_en", iram_en_b, 1'b1);
    tick();
    chk("t2_wait1_en",    iram_en_b, 1'b1);
    chk("t2_wait1_fetch", fetch_b,   1'b0);
    tick();
    chk("t2_wait2_fetch", fetch_b,     1'b0);
    chk("t2_wait2_valid", ins_valid_b, 1'b0);
    tick();
    chk("t2_load_fetch", fetch_b, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", ins_valid_b, 1'b1);
      chk("t2_hold_fetch", fetch_b,     1'b0);
      chk("t2_hold_pc",    pc_b,        8'h00);
      tick();
    end
    rdy_b = 1'b1;
    tick();
    qb.push_back(8'h01);
    chk("t2_ack_pc", pc_b,      8'h01);
    chk("t2_ack_en", iram_en_b, 1'b1);

    // Test 4: run dropped during WAIT; fetch completes then FSM idles.
    rdy_b = 1'b0;
    tick();
    run_b = 1'b0;
    tick(); tick();
    chk("t4_load_fetch", fetch_b, 1'b1);
    tick();
    chk("t4_valid", ins_valid_b, 1'b1);
    rdy_b = 1'b1;
    tick();
    chk("t4_idle_pc", pc_b, 8'h02);
    for (int i = 0; i < 3; i++) begin
      chk("t4_idle_en", iram_en_b, 1'b0);
      tick();
    end

    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
